spi_slave: RTL and testbench

//  SPI responder: the far end of a spi_master link. Receives MOSI bytes MSB-first
//  and returns a preloaded byte on MISO in the same frame. Samples the external
//  spi_cs/spi_clk/spi_mosi, asynchronous to clk, through synchronizers. Delivers

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 135 +++++++++++++
 tb/tb_spi_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_master / spi_slave pair.
package spi_pkg;

  localparam int unsigned SPI_W = 8;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input with rise/fall strobes
// derived from the synchronized level and its registered previous value.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_sr <= {STAGES{RST_VAL}};
      prev    <= RST_VAL;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], din};
      prev    <= sync_sr[STAGES-1];
    end
  end

  assign sync_out = sync_sr[STAGES-1];
  assign rise     = sync_sr[STAGES-1] & ~prev;
  assign fall     = ~sync_sr[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: shifts in MOSI bytes MSB-first, returns a preloaded byte on
// MISO, and strobes each received byte to the fabric on rx_valid.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [SPI_W-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [SPI_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             spi_busy,
  output logic             tx_underrun
);

  logic cs_s, cs_rise, cs_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // Chip select idles deasserted so reset never looks like a frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi_clk),
    .sync_out(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e       state;
  logic [2:0]       bit_cnt;
  logic [SPI_W-1:0] rx_sr;
  logic [SPI_W-1:0] tx_sr;
  logic [SPI_W-1:0] tx_buf;

  logic lead, trail, sample_ev, shift_ev, byte_start, tx_accept;
  logic [SPI_W-1:0] next_tx;

  always_comb begin
    lead       = CPOL ? sck_fall : sck_rise;
    trail      = CPOL ? sck_rise : sck_fall;
    sample_ev  = ~cs_s & (CPHA ? trail : lead);
    shift_ev   = ~cs_s & (CPHA ? lead : trail);
    byte_start = ((state == ST_IDLE) && cs_fall) ||
                 ((state == ST_ACTIVE) && sample_ev && (bit_cnt == 3'd7));
    next_tx    = tx_ready ? '0 : tx_buf;
    tx_accept  = tx_load & tx_ready;
  end

  assign spi_busy = ~cs_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      spi_miso    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // A load in the byte-start cycle fills the buffer for the following byte.
      if (tx_accept) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (byte_start) begin
        tx_ready <= 1'b1;
      end

      if (byte_start && tx_ready) tx_underrun <= 1'b1;
      else if (tx_accept)         tx_underrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= next_tx;
            spi_miso <= CPHA ? 1'b0 : next_tx[SPI_W-1];
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            spi_miso <= 1'b0;
          end else if (sample_ev) begin
            rx_sr   <= {rx_sr[SPI_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {rx_sr[SPI_W-2:0], mosi_s};
              rx_valid <= 1'b1;
              tx_sr    <= next_tx;
              if (!CPHA) spi_miso <= next_tx[SPI_W-1];
            end
          end else if (shift_ev) begin
            // bit_cnt==0 marks the first shift edge of a byte: CPHA=1 presents
            // bit 7 there, CPHA=0 already drove it at byte start.
            if (bit_cnt != 3'd0) begin
              tx_sr    <= {tx_sr[SPI_W-2:0], 1'b0};
              spi_miso <= tx_sr[SPI_W-2];
            end else if (CPHA) begin
              spi_miso <= tx_sr[SPI_W-1];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a master task driving
// frames, and a scoreboard monitor checking every rx_valid strobe.
module tb_spi_slave;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cs = 4'hF;
  logic [3:0] sclk = 4'b1100;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_load = 4'h0;
  logic [3:0] miso, tx_ready, rx_valid, busy, unr;
  logic [7:0] rx_data [4];

  int n_cmp = 0;
  int n_bad = 0;
  rx_exp_t sb_q[$];

  logic [7:0] m_buf  [4];
  bit         m_full [4];
  bit         m_unr  [4];
  logic [7:0] m_last [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    localparam logic P_CPOL = (m / 2) == 1;
    localparam logic P_CPHA = (m % 2) == 1;
    spi_slave #(.CPOL(P_CPOL), .CPHA(P_CPHA), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .spi_cs(cs[m]), .spi_clk(sclk[m]), .spi_mosi(mosi),
      .spi_miso(miso[m]), .tx_data(tx_data), .tx_load(tx_load[m]),
      .tx_ready(tx_ready[m]), .rx_data(rx_data[m]), .rx_valid(rx_valid[m]),
      .spi_busy(busy[m]), .tx_underrun(unr[m])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model of the tx buffer: each byte start consumes it or underruns.
  function automatic logic [7:0] take(input int idx);
    if (m_full[idx]) begin
      m_full[idx] = 1'b0;
      return m_buf[idx];
    end
    m_unr[idx] = 1'b1;
    return 8'h00;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = 8'h00; m_full[i] = 1'b0; m_unr[i] = 1'b0; m_last[i] = 8'h00;
    end
  endfunction

  task automatic load(input int idx, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load[idx] = 1'b1;
    if (!m_full[idx]) begin
      m_buf[idx] = d; m_full[idx] = 1'b1; m_unr[idx] = 1'b0;
    end
    @(negedge clk);
    tx_load[idx] = 1'b0;
  endtask

  task automatic check_flags(input int idx);
    check("tx_ready", 32'(tx_ready[idx]), 32'(!m_full[idx]));
    check("tx_underrun", 32'(unr[idx]), 32'(m_unr[idx]));
    check("rx_data_hold", 32'(rx_data[idx]), 32'(m_last[idx]));
  endtask

  task automatic check_reset(input int idx);
    check("reset_state",
          32'({miso[idx], tx_ready[idx], rx_valid[idx], busy[idx], unr[idx], rx_data[idx]}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
  endtask

  // Master: sends nbits of mo MSB-first; checks MISO per completed byte.
  task automatic frame(input int idx, input int nbits, input logic [15:0] mo, input bit keep_cs);
    logic       cpol, cpha;
    logic [7:0] exp_mi, got_mi, rxb;
    int         bi;
    cpol   = (idx >= 2);
    cpha   = (idx % 2) == 1;
    got_mi = 8'h00;
    exp_mi = take(idx);
    if (!cpha) mosi = mo[15];
    cs[idx] = 1'b0;
    #100;
    check("busy_in_frame", 32'(busy[idx]), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      bi = 7 - (b % 8);
      if (!cpha) begin
        got_mi[bi] = miso[idx];
        sclk[idx] = ~cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = mo[15-b];
        #50;
        got_mi[bi] = miso[idx];
        sclk[idx] = cpol;
      end
      if (b % 8 == 7) begin
        rxb = (b == 7) ? mo[15:8] : mo[7:0];
        sb_q.push_back('{idx: 2'(idx), data: rxb});
        m_last[idx] = rxb;
        check("miso_byte", 32'(got_mi), 32'(exp_mi));
        exp_mi = take(idx);
      end
      if (!cpha) begin
        #50;
        sclk[idx] = cpol;
        if (b + 1 < nbits) mosi = mo[14-b];
      end
      #50;
    end
    if (!keep_cs) begin
      cs[idx] = 1'b1;
      #100;
      check("miso_deselected", 32'(miso[idx]), 32'd0);
      check("busy_after_frame", 32'(busy[idx]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_unexpected: inst %0d got %0h expected no strobe", i, rx_data[i]);
        end else begin
          rx_exp_t e;
          e = sb_q.pop_front();
          check("rx_inst", 32'(i), 32'(e.idx));
          check("rx_data", 32'(rx_data[i]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    model_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) check_reset(i);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0: 8'hA5 in, preloaded 8'h5A out
    load(0, 8'h5A);
    check_flags(0);
    frame(0, 8, 16'hA500, 1'b0);
    check_flags(0);

    // Modes 1..3 with 8'h3C
    for (int i = 1; i < 4; i++) begin
      load(i, 8'($urandom));
      frame(i, 8, 16'h3C00, 1'b0);
      check_flags(i);
    end

    // Two back-to-back bytes in one frame; second tx byte loaded mid-frame
    load(0, 8'h11);
    fork
      frame(0, 16, 16'h3CC3, 1'b0);
      begin
        k = 0;
        @(negedge clk);
        while (tx_ready[0] !== 1'b1 && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("tx_ready_mid_frame", 32'(tx_ready[0]), 32'd1);
        load(0, 8'h22);
      end
    join
    check_flags(0);

    // CS aborted after 3 bits: no strobe, rx_data held
    frame(0, 3, 16'hFF00, 1'b0);
    check_flags(0);
    frame(0, 8, 16'h8100, 1'b0);
    check_flags(0);

    // Randomized frames across all modes
    for (int t = 0; t < 12; t++) begin
      int idx;
      idx = int'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) load(idx, 8'($urandom));
      frame(idx, ($urandom_range(1, 0) == 1) ? 16 : 8, 16'($urandom), 1'b0);
      check_flags(idx);
    end

    // Reset mid-byte, then fresh frame with an empty tx buffer
    load(0, 8'hE7);
    frame(0, 4, 16'hB000, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(0);
    cs[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset(0);
    frame(0, 8, 16'h4200, 1'b0);
    check_flags(0);
    load(0, 8'h77);
    check_flags(0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
